instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 5, instruction word-address width.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first address fetched after reset.
REQ-004 Parameter PROG_LEN, default 32, number of sequential words fetched before the block stops (1..2^ADDR_W).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 imem_addr  out  ADDR_W  word address to the synchronous-read instruction memory, combinational from state and inputs.
REQ-008 imem_instr  in  DATA_W  memory data, valid in the cycle after its address was sampled.
REQ-009 stall  in  1  decode cannot accept the presented instruction this cycle.
REQ-010 redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-011 redirect_pc  in  ADDR_W  redirect target.
REQ-012 if_instr  out  DATA_W  instruction to decode; equals imem_instr.
REQ-013 if_pc  out  ADDR_W  address of if_instr.
REQ-014 if_valid  out  1  if_instr/if_pc valid.
REQ-015 done  out  1  program fully fetched and accepted.

Function
REQ-016 The block SHALL hold registers fetch_pc (next address), req_pc (address sampled by memory at last edge), req_valid, and state in {RUN, LAST, DONE}.
REQ-017 imem_addr SHALL be: redirect ? redirect_pc : (stall & req_valid) ? req_pc : fetch_pc; redirect has priority over stall.
REQ-018 if_pc SHALL equal req_pc; if_valid SHALL equal req_valid & ~redirect & (state != DONE).
REQ-019 An instruction is accepted in a cycle with if_valid=1 and stall=0.
REQ-020 On redirect (any state): req_pc<=redirect_pc, req_valid<=1, fetch_pc<=redirect_pc+1, state<=RUN, or LAST if redirect_pc==PROG_LEN-1; done<=0.
REQ-021 On stall without redirect: fetch_pc, req_pc, req_valid, state SHALL hold; memory re-reads req_pc so if_instr stays stable.
REQ-022 In RUN without stall/redirect: req_pc<=fetch_pc, req_valid<=1, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W); if the issued address is PROG_LEN-1, state<=LAST.
REQ-023 In LAST without stall/redirect: no new issue; when the PROG_LEN-1 instruction is accepted, req_valid<=0, state<=DONE, done<=1.
REQ-024 In DONE: if_valid=0, done=1, imem_addr=fetch_pc, state held until redirect or reset.
REQ-025 Latency: address issued at edge N SHALL appear on if_instr/if_valid during cycle N+1; sustained throughput one instruction per cycle.
REQ-026 Redirect latency: redirect in cycle N SHALL produce if_valid=1, if_pc=redirect_pc in cycle N+1; the instruction present in cycle N is discarded.
REQ-027 Stall asserted while req_valid=0 SHALL not block issue of the first fetch.

Reset
REQ-028 While rst=1: fetch_pc=RESET_PC, req_pc=RESET_PC, req_valid=0, state=RUN (LAST if PROG_LEN==1), done=0, if_valid=0, imem_addr=RESET_PC.
REQ-029 Reset asserted mid-operation SHALL immediately drop if_valid and done and discard any in-flight fetch; first valid output comes one cycle after the first rising edge following deassertion.

Structure
REQ-030 ADDR_W, DATA_W and the state encoding SHALL live in the shared MIPS defines include, reused by the memory and decode blocks.
REQ-031 No sub-module; the instruction memory is instantiated beside this block at the same level, not inside it.

Verification (instruction_memory preloaded 0x20010003, 0x20020003, 0x00221818, 0x8C41000A, 0x10220014 at 0..4; PROG_LEN=5)
REQ-032 Release reset, no stall -> cycles 1..5 if_pc 0..4 with those words, if_valid=1; cycle 6 if_valid=0, done=1.
REQ-033 stall high in cycle 2 (if_pc=1) for 3 cycles -> if_pc=1, if_instr=0x20020003 held 4 cycles; sequence then resumes at 2 with nothing lost or duplicated.
REQ-034 redirect=1, redirect_pc=0 while if_pc=3 -> next cycle if_pc=0, if_instr=0x20010003; words 3 and 4 of the old stream never accepted.
REQ-035 redirect and stall both high in one cycle -> redirect wins; next cycle if_pc=redirect_pc.
REQ-036 rst pulsed while if_pc=2 and stall=1 -> if_valid=0 immediately; after release stream restarts at 0.
REQ-037 In DONE, redirect_pc=4 -> one cycle if_pc=4, if_instr=0x10220014, then DONE again.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared MIPS fetch definitions: default widths and the fetch state encoding,
// reused by the instruction memory and decode blocks.
package instruction_fetch_pkg;

    localparam int IF_ADDR_W = 5;
    localparam int IF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LAST = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch for a synchronous-read instruction memory, with
// decode back-pressure (stall), branch redirect and end-of-program detection.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W   = IF_ADDR_W,
    parameter int DATA_W   = IF_DATA_W,
    parameter int RESET_PC = 0,
    parameter int PROG_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              done
);

    localparam logic [ADDR_W-1:0] START_PC    = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_PC     = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE         = ADDR_W'(1);
    localparam fetch_state_t      RESET_STATE = (PROG_LEN == 1) ? ST_LAST : ST_RUN;

    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0] req_pc, req_pc_nxt;
    logic              req_valid, req_valid_nxt;
    fetch_state_t      state, state_nxt;
    logic              hold;

    // A stall only freezes the pipe when there is an instruction to hold;
    // with nothing presented the first fetch still goes out.
    assign hold = stall & req_valid;

    always_comb begin
        if (rst)
            imem_addr = START_PC;
        else if (redirect)
            imem_addr = redirect_pc;
        else if (hold)
            imem_addr = req_pc;
        else
            imem_addr = fetch_pc;
    end

    assign if_instr = imem_instr;
    assign if_pc    = req_pc;
    assign if_valid = req_valid & ~redirect & (state != ST_DONE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= START_PC;
            req_pc    <= START_PC;
            req_valid <= 1'b0;
            state     <= RESET_STATE;
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            req_pc    <= req_pc_nxt;
            req_valid <= req_valid_nxt;
            state     <= state_nxt;
        end
    end

    always_comb begin
        fetch_pc_nxt  = fetch_pc;
        req_pc_nxt    = req_pc;
        req_valid_nxt = req_valid;
        state_nxt     = state;

        if (redirect) begin
            req_pc_nxt    = redirect_pc;
            req_valid_nxt = 1'b1;
            fetch_pc_nxt  = redirect_pc + ONE;
            if (redirect_pc == LAST_PC)
                state_nxt = ST_LAST;
            else
                state_nxt = ST_RUN;
        end else if (!hold) begin
            unique case (state)
                ST_RUN: begin
                    req_pc_nxt    = fetch_pc;
                    req_valid_nxt = 1'b1;
                    fetch_pc_nxt  = fetch_pc + ONE;
                    if (fetch_pc == LAST_PC)
                        state_nxt = ST_LAST;
                end
                ST_LAST: begin
                    // Last word already in flight: retire it once accepted.
                    // Only a one-word program reaches here with nothing issued.
                    if (req_valid) begin
                        req_valid_nxt = 1'b0;
                        state_nxt     = ST_DONE;
                    end else begin
                        req_pc_nxt    = fetch_pc;
                        req_valid_nxt = 1'b1;
                        fetch_pc_nxt  = fetch_pc + ONE;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_nxt = ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a stream-level reference model checked
// every cycle, plus literal expectations for the preloaded five-word program.
module tb_instruction_fetch;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int PROG_LEN = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem [0:31];
    logic [DATA_W-1:0] prog [0:4];

    instruction_fetch #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(0),
        .PROG_LEN(PROG_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory sitting beside the fetch block.
    always @(posedge clk) imem_instr <= mem[imem_addr];

    // Reference model: which word is presented, whether the program is done,
    // and the last word presented since reset.
    logic              m_valid;
    logic              m_done;
    logic              m_started;
    logic [ADDR_W-1:0] m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_done    <= 1'b0;
            m_started <= 1'b0;
            m_last    <= '0;
        end else if (redirect) begin
            m_valid   <= 1'b1;
            m_done    <= 1'b0;
            m_started <= 1'b1;
            m_last    <= redirect_pc;
        end else if (!m_started) begin
            m_valid   <= 1'b1;
            m_started <= 1'b1;
            m_last    <= '0;
        end else if (m_valid && !stall) begin
            if (int'(m_last) == PROG_LEN - 1) begin
                m_valid <= 1'b0;
                m_done  <= 1'b1;
            end else begin
                m_last <= 5'(m_last + 5'd1);
            end
        end
    end

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_valid;
        exp_valid = m_valid & ~redirect & ~rst;
        if (rst || !m_started)
            exp_addr = '0;
        else if (redirect)
            exp_addr = redirect_pc;
        else if (m_valid && stall)
            exp_addr = m_last;
        else
            exp_addr = 5'(m_last + 5'd1);
        if (rst && redirect)
            exp_addr = '0;
        compareValue("model_if_valid", 32'(if_valid), 32'(exp_valid));
        compareValue("model_done", 32'(done), 32'(m_done & ~rst));
        compareValue("model_imem_addr", 32'(imem_addr), 32'(exp_addr));
        if (exp_valid) begin
            compareValue("model_if_pc", 32'(if_pc), 32'(m_last));
            compareValue("model_if_instr", if_instr, mem[m_last]);
        end
    end

    task automatic checkOutput(input string name, input logic v, input logic [ADDR_W-1:0] pc,
                               input logic [DATA_W-1:0] instr, input logic d);
        compareValue({name, "_valid"}, 32'(if_valid), 32'(v));
        compareValue({name, "_done"}, 32'(done), 32'(d));
        if (v) begin
            compareValue({name, "_pc"}, 32'(if_pc), 32'(pc));
            compareValue({name, "_instr"}, if_instr, instr);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [ADDR_W-1:0] rpc);
        @(posedge clk);
        #1;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    // Leaves the bench in cycle 0: reset just released, no edge seen yet.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1;
        checkOutput("reset", 1'b0, '0, '0, 1'b0);
        compareValue("reset_imem_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        prog[0] = 32'h20010003;
        prog[1] = 32'h20020003;
        prog[2] = 32'h00221818;
        prog[3] = 32'h8C41000A;
        prog[4] = 32'h10220014;
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD0000 | 32'(i);
        for (int i = 0; i < 5; i++) mem[i] = prog[i];

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        $display("[TB] straight-line program");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("seq", 1'b1, 5'(i), prog[i], 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("seq_end", 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("seq_idle", 1'b0, '0, '0, 1'b1);
        compareValue("done_imem_addr", 32'(imem_addr), 32'd5);

        $display("[TB] redirect out of done to the last word");
        applyStimulus(1'b0, 1'b1, 5'd4);
        checkOutput("done_redir", 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("done_redir_word", 1'b1, 5'd4, prog[4], 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("done_again", 1'b0, '0, '0, 1'b1);

        $display("[TB] stall before first fetch, then stall on word 1");
        doReset();
        stall = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("first_fetch", 1'b1, 5'd0, prog[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i < 3, 1'b0, '0);
            checkOutput("stall_hold", 1'b1, 5'd1, prog[1], 1'b0);
        end
        for (int i = 2; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("stall_resume", 1'b1, 5'(i), prog[i], 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("stall_end", 1'b0, '0, '0, 1'b1);

        $display("[TB] redirect back to 0 while word 3 is presented");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 5'd0);
        compareValue("redir_if_pc", 32'(if_pc), 32'd3);
        checkOutput("redir_discard", 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("redir_stream", 1'b1, 5'(i), prog[i], 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("redir_end", 1'b0, '0, '0, 1'b1);

        $display("[TB] redirect and stall together, then stall on the last word");
        doReset();
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 5'd2);
        checkOutput("both_discard", 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("both_target", 1'b1, 5'd2, prog[2], 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("both_next", 1'b1, 5'd3, prog[3], 1'b0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("last_stall", 1'b1, 5'd4, prog[4], 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("last_release", 1'b1, 5'd4, prog[4], 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("last_done", 1'b0, '0, '0, 1'b1);

        $display("[TB] reset pulse during a stall");
        doReset();
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("pre_reset", 1'b1, 5'd2, prog[2], 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("reset_release", 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("restart", 1'b1, 5'(i), prog[i], 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("restart_end", 1'b0, '0, '0, 1'b1);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
